// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory side of the
// data-memory arbiter. The slave modport is the arbiter's view; the master
// modport is the requester-plus-memory side that surrounds it.
interface dmem_arbiter_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          M0Req;
   logic          M0We;
   logic [AW-1:0] M0Addr;
   logic [DW-1:0] M0WData;
   logic          M0Ack;
   logic [DW-1:0] M0RData;

   logic          M1Req;
   logic          M1We;
   logic [AW-1:0] M1Addr;
   logic [DW-1:0] M1WData;
   logic          M1Ack;
   logic [DW-1:0] M1RData;

   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemWData;
   logic          MemW;
   logic          MemR;
   logic [DW-1:0] MemRData;

   logic          Busy;

   modport slave (
      input  M0Req, M0We, M0Addr, M0WData,
      input  M1Req, M1We, M1Addr, M1WData,
      input  MemRData,
      output M0Ack, M0RData, M1Ack, M1RData,
      output MemAddr, MemWData, MemW, MemR, Busy
   );

   modport master (
      output M0Req, M0We, M0Addr, M0WData,
      output M1Req, M1We, M1Addr, M1WData,
      output MemRData,
      input  M0Ack, M0RData, M1Ack, M1RData,
      input  MemAddr, MemWData, MemW, MemR, Busy
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the CPU load/store stage, port 1 the debug/loader port.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | waiting for a request; arbitrates and latches the winner
//   ACCESS | drives the memory for one cycle from the latched operands
//   RESP   | pulses the winner's ack; updates the last-grant pointer
module dmem_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic           CLK,
   input  logic           RST_N,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          win_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          last_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;
   logic          any_req;
   logic          grant;

   assign any_req = bus.M0Req | bus.M1Req;

   // Winner selection: a lone requester wins; on a tie the port not granted last time wins.
   always_comb begin
      grant = 1'b0;
      if (bus.M0Req && bus.M1Req) begin
         grant = ~last_q;
      end else if (bus.M1Req) begin
         grant = 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the winner and its operands when leaving IDLE; later operand changes are ignored.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (state_q == IDLE && any_req) begin
         win_q   <= grant;
         we_q    <= grant ? bus.M1We    : bus.M0We;
         addr_q  <= grant ? bus.M1Addr  : bus.M0Addr;
         wdata_q <= grant ? bus.M1WData : bus.M0WData;
      end
   end

   // Last-grant pointer; reset to 1 so port 0 wins the first tie.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_q <= 1'b1;
      end else if (state_q == RESP) begin
         last_q <= win_q;
      end
   end

   // Capture read data into the winner's register only; the other port keeps its value.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else if (state_q == ACCESS && !we_q) begin
         if (win_q) begin
            rdata1_q <= bus.MemRData;
         end else begin
            rdata0_q <= bus.MemRData;
         end
      end
   end

   // Memory strobes decode from registers only, so they are glitch-free and drop at once on reset.
   assign bus.MemW     = (state_q == ACCESS) &&  we_q;
   assign bus.MemR     = (state_q == ACCESS) && !we_q;
   assign bus.MemAddr  = (state_q == ACCESS) ? addr_q  : '0;
   assign bus.MemWData = (state_q == ACCESS) ? wdata_q : '0;

   assign bus.M0Ack    = (state_q == RESP) && !win_q;
   assign bus.M1Ack    = (state_q == RESP) &&  win_q;
   assign bus.M0RData  = rdata0_q;
   assign bus.M1RData  = rdata1_q;
   assign bus.Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked against a reference built from the arbitration and memory rules.
module tb_dmem_arbiter;

   logic clk;
   logic rst_n;

   dmem_arbiter_if #(.AW(5), .DW(32)) ifc ();

   dmem_arbiter #(.AW(5), .DW(32)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic        req   [2];
   logic        we    [2];
   logic [4:0]  addr  [2];
   logic [31:0] wd    [2];

   assign ifc.M0Req   = req[0];
   assign ifc.M0We    = we[0];
   assign ifc.M0Addr  = addr[0];
   assign ifc.M0WData = wd[0];
   assign ifc.M1Req   = req[1];
   assign ifc.M1We    = we[1];
   assign ifc.M1Addr  = addr[1];
   assign ifc.M1WData = wd[1];

   // Single-port memory: combinational read, write on rising clock.
   logic [31:0] mem [32] = '{default: 32'h0};
   always @(posedge clk) begin
      if (ifc.MemW) mem[ifc.MemAddr] <= ifc.MemWData;
   end
   assign ifc.MemRData = mem[ifc.MemAddr];

   // Reference state.
   logic [31:0] mm     [32] = '{default: 32'h0};
   logic [31:0] exp_rd [2];
   bit          last_m;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_memw"}, ifc.MemW, 0);
      chk({tag, "_memr"}, ifc.MemR, 0);
      chk({tag, "_busy"}, ifc.Busy, 0);
      chk({tag, "_ack0"}, ifc.M0Ack, 0);
      chk({tag, "_ack1"}, ifc.M1Ack, 0);
   endtask

   // One full transaction, starting at a negedge in IDLE with requests driven.
   task automatic txn(input bit drop, output bit w);
      bit          lw;
      logic [4:0]  la;
      logic [31:0] ld;
      if (req[0] && req[1]) w = ~last_m;
      else                  w = req[1];
      lw = we[w];
      la = addr[w];
      ld = wd[w];
      @(posedge clk); @(negedge clk);
      chk("acc_busy", ifc.Busy, 1);
      chk("acc_memw", ifc.MemW, lw);
      chk("acc_memr", ifc.MemR, !lw);
      chk("acc_addr", ifc.MemAddr, la);
      if (lw) chk("acc_wdata", ifc.MemWData, ld);
      chk("acc_ack0", ifc.M0Ack, 0);
      chk("acc_ack1", ifc.M1Ack, 0);
      if (drop) begin
         req[w]  = 1'b0;
         addr[w] = ~addr[w];
         wd[w]   = ~wd[w];
      end
      @(posedge clk); @(negedge clk);
      if (lw) mm[la] = ld;
      else    exp_rd[w] = mm[la];
      chk("rsp_ack0", ifc.M0Ack, (w == 1'b0));
      chk("rsp_ack1", ifc.M1Ack, (w == 1'b1));
      chk("rsp_memw", ifc.MemW, 0);
      chk("rsp_memr", ifc.MemR, 0);
      chk("rsp_busy", ifc.Busy, 1);
      chk("rsp_rdata0", ifc.M0RData, exp_rd[0]);
      chk("rsp_rdata1", ifc.M1RData, exp_rd[1]);
      last_m = w;
      req[w] = 1'b0;
      @(posedge clk); @(negedge clk);
      chk_idle("post");
   endtask

   task automatic raise(input int p, input bit w_en, input logic [4:0] a, input logic [31:0] d);
      req[p]  = 1'b1;
      we[p]   = w_en;
      addr[p] = a;
      wd[p]   = d;
   endtask

   initial begin
      bit w;
      rst_n = 1'b0;
      for (int p = 0; p < 2; p++) begin
         req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wd[p] = '0;
         exp_rd[p] = '0;
      end
      last_m = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset then idle.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_idle("idle");
         chk("idle_rdata0", ifc.M0RData, 0);
         chk("idle_rdata1", ifc.M1RData, 0);
      end

      // First contention: port 0 first, port 1 in the following transaction.
      raise(0, 1'b1, 5'd10, 32'h1111_1111);
      raise(1, 1'b1, 5'd11, 32'h2222_2222);
      txn(1'b0, w);
      txn(1'b0, w);

      // Port 0 write then read of address 3.
      raise(0, 1'b1, 5'd3, 32'hDEAD_BEEF);
      txn(1'b0, w);
      raise(0, 1'b0, 5'd3, 32'h0);
      txn(1'b0, w);
      chk("p0_read3", ifc.M0RData, 32'hDEAD_BEEF);

      // Sustained contention, both ports re-requesting after each ack.
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req[p]) raise(p, 1'($urandom_range(0, 1)), 5'(16 + $urandom_range(0, 7)), $urandom);
         end
         txn(1'b0, w);
      end

      // Port 1 write dropped after grant still lands; read it back.
      raise(1, 1'b1, 5'd31, 32'h1234_5678);
      txn(1'b1, w);
      raise(1, 1'b0, 5'd31, 32'h0);
      txn(1'b0, w);
      chk("p1_read31", ifc.M1RData, 32'h1234_5678);

      // Reset during the ACCESS cycle of a write suppresses it.
      raise(0, 1'b1, 5'd7, 32'hCAFE_F00D);
      @(posedge clk); @(negedge clk);
      chk("rstw_memw_before", ifc.MemW, 1);
      rst_n = 1'b0;
      #1;
      chk("rstw_memw_after", ifc.MemW, 0);
      chk("rstw_busy", ifc.Busy, 0);
      chk("rstw_ack0", ifc.M0Ack, 0);
      chk("rstw_rdata0", ifc.M0RData, 0);
      req[0] = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      last_m = 1'b1;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("rstw_idle");
      raise(0, 1'b0, 5'd7, 32'h0);
      txn(1'b0, w);
      chk("read7_after_rst", ifc.M0RData, 32'h0);

      // Random traffic.
      for (int i = 0; i < 60; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!req[p] && $urandom_range(0, 1) == 1)
               raise(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         end
         if (!req[0] && !req[1])
            raise(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         txn(1'($urandom_range(0, 3) == 0), w);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
